// File: rtl/mem_rd_arbiter_pkg.sv
// Shared definitions for the icache/dcache read arbiter.
// Line width, read-type encodings and arbiter state codes.
package mem_rd_arbiter_pkg;

   localparam int LINE_WIDTH = 256;

   typedef enum logic [2:0] {
      RD_BYTE = 3'd0,
      RD_HALF = 3'd1,
      RD_WORD = 3'd2,
      RD_LINE = 3'd4
   } rd_type_e;

   typedef logic [2:0] arb_state_t;

   localparam arb_state_t IDLE   = 3'd0;
   localparam arb_state_t HOLD_I = 3'd1;
   localparam arb_state_t HOLD_D = 3'd2;
   localparam arb_state_t RET_I  = 3'd3;
   localparam arb_state_t RET_D  = 3'd4;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Cache-side memory port: read request, return beats, write line.
// The _ro modports carry the read channel only.
interface mem_rd_arbiter_if #(
   parameter int LINE_WIDTH = mem_rd_arbiter_pkg::LINE_WIDTH
);

   logic                  rd_req;
   logic [2:0]            rd_type;
   logic [31:0]           rd_addr;
   logic                  rd_rdy;
   logic                  ret_valid;
   logic                  ret_last;
   logic [31:0]           ret_data;
   logic                  wr_req;
   logic [2:0]            wr_type;
   logic [31:0]           wr_addr;
   logic [3:0]            wr_wstrb;
   logic [LINE_WIDTH-1:0] wr_data;
   logic                  wr_rdy;

   modport master (
      output rd_req, rd_type, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data,
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  wr_rdy
   );

   modport slave (
      input  rd_req, rd_type, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data,
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output wr_rdy
   );

   modport master_ro (
      output rd_req, rd_type, rd_addr,
      input  rd_rdy, ret_valid, ret_last, ret_data
   );

   modport slave_ro (
      input  rd_req, rd_type, rd_addr,
      output rd_rdy, ret_valid, ret_last, ret_data
   );

endinterface

// File: rtl/mem_rd_arbiter.sv
// Two-master read arbiter (icache/dcache) in front of the AXI bridge.
// One read outstanding; data has priority with an inst anti-starve limit.
module mem_rd_arbiter #(
   parameter int LINE_WIDTH   = mem_rd_arbiter_pkg::LINE_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   mem_rd_arbiter_if.slave_ro        inst,
   mem_rd_arbiter_if.slave           data,
   mem_rd_arbiter_if.master          mem
);

   import mem_rd_arbiter_pkg::*;

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic [CW-1:0]         starve_cnt;
   logic [CW-1:0]         starve_nxt;
   logic                  starved;
   logic                  sel_i;
   logic                  sel_d;
   logic                  acc_i;
   logic                  acc_d;
   logic                  ret_i;
   logic                  ret_d;
   logic                  ret_done;
   logic [LINE_WIDTH-1:0] wr_line;

   assign starved  = (starve_cnt == CW'(STARVE_LIMIT));
   assign acc_i    = sel_i & inst.rd_req & mem.rd_rdy;
   assign acc_d    = sel_d & data.rd_req & mem.rd_rdy;
   assign ret_done = mem.ret_valid & mem.ret_last;

   // Selection, next state and starve counter update.
   always_comb begin
      sel_i      = 1'b0;
      sel_d      = 1'b0;
      state_nxt  = state;
      starve_nxt = starve_cnt;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               sel_i = inst.rd_req & (~data.rd_req | starved);
               sel_d = data.rd_req & ~sel_i;
            end
            HOLD_I:  sel_i = 1'b1;
            HOLD_D:  sel_d = 1'b1;
            default: ;
         endcase
      end
      unique case (state)
         IDLE: begin
            if (acc_i)
               state_nxt = RET_I;
            else if (acc_d)
               state_nxt = RET_D;
            else if (sel_i)
               state_nxt = HOLD_I;
            else if (sel_d)
               state_nxt = HOLD_D;
         end
         HOLD_I: begin
            if (!inst.rd_req)
               state_nxt = IDLE;
            else if (acc_i)
               state_nxt = RET_I;
         end
         HOLD_D: begin
            if (!data.rd_req)
               state_nxt = IDLE;
            else if (acc_d)
               state_nxt = RET_D;
         end
         RET_I, RET_D: begin
            if (ret_done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (!inst.rd_req || acc_i)
         starve_nxt = '0;
      else if (acc_d && !starved)
         starve_nxt = starve_cnt + 1'b1;
   end

   // Arbiter state and starve counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Protocol checks: held request dropped, stray return beats.
   always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
         if (state == HOLD_I)
            assert (inst.rd_req)
               else $error("arbiter: held inst read request dropped");
         if (state == HOLD_D)
            assert (data.rd_req)
               else $error("arbiter: held data read request dropped");
         if (state == IDLE || state == HOLD_I || state == HOLD_D)
            assert (!mem.ret_valid)
               else $error("arbiter: return beat with no read outstanding");
      end
   end

   assign mem.rd_req  = (sel_i & inst.rd_req) | (sel_d & data.rd_req);
   assign mem.rd_type = sel_i ? inst.rd_type :
                        sel_d ? data.rd_type : 3'd0;
   assign mem.rd_addr = sel_i ? inst.rd_addr :
                        sel_d ? data.rd_addr : 32'd0;
   assign inst.rd_rdy = sel_i & mem.rd_rdy;
   assign data.rd_rdy = sel_d & mem.rd_rdy;

   assign ret_i = ~reset & (state == RET_I);
   assign ret_d = ~reset & (state == RET_D);

   assign inst.ret_valid = ret_i & mem.ret_valid;
   assign inst.ret_last  = ret_i & mem.ret_last;
   assign inst.ret_data  = ret_i ? mem.ret_data : 32'd0;
   assign data.ret_valid = ret_d & mem.ret_valid;
   assign data.ret_last  = ret_d & mem.ret_last;
   assign data.ret_data  = ret_d ? mem.ret_data : 32'd0;

   assign wr_line      = reset ? '0 : data.wr_data;
   assign mem.wr_req   = ~reset & data.wr_req;
   assign mem.wr_type  = reset ? 3'd0 : data.wr_type;
   assign mem.wr_addr  = reset ? 32'd0 : data.wr_addr;
   assign mem.wr_wstrb = reset ? 4'd0 : data.wr_wstrb;
   assign mem.wr_data  = wr_line;
   assign data.wr_rdy  = ~reset & mem.wr_rdy;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a return-beat scoreboard.
// Covers refill, starve rotation, hold lock, writes and reset.
module tb_mem_rd_arbiter;

   localparam int LW = 256;

   typedef struct {
      bit          to_inst;
      logic [31:0] data;
      bit          last;
   } beat_t;

   logic  clk;
   logic  reset;
   int    errors = 0;
   int    checks = 0;
   beat_t sb[$];
   string order = "DDDDIDDDDI";

   mem_rd_arbiter_if #(.LINE_WIDTH(LW)) inst_if ();
   mem_rd_arbiter_if #(.LINE_WIDTH(LW)) data_if ();
   mem_rd_arbiter_if #(.LINE_WIDTH(LW)) mem_if ();

   mem_rd_arbiter #(
      .LINE_WIDTH  (LW),
      .STARVE_LIMIT(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .inst (inst_if),
      .data (data_if),
      .mem  (mem_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit ti, input logic [31:0] d, input bit l);
      beat_t e;
      mem_if.ret_valid = 1'b1;
      mem_if.ret_last  = l;
      mem_if.ret_data  = d;
      sb.push_back('{to_inst: ti, data: d, last: l});
      #1;
      e = sb.pop_front();
      if (e.to_inst) begin
         chk("ret_i_valid", 256'(inst_if.ret_valid), 256'(1));
         chk("ret_i_data", 256'(inst_if.ret_data), 256'(e.data));
         chk("ret_i_last", 256'(inst_if.ret_last), 256'(e.last));
         chk("ret_d_quiet", 256'(data_if.ret_valid), 256'(0));
      end else begin
         chk("ret_d_valid", 256'(data_if.ret_valid), 256'(1));
         chk("ret_d_data", 256'(data_if.ret_data), 256'(e.data));
         chk("ret_d_last", 256'(data_if.ret_last), 256'(e.last));
         chk("ret_i_quiet", 256'(inst_if.ret_valid), 256'(0));
      end
      chk("no_grant_in_ret",
          256'({mem_if.rd_req, inst_if.rd_rdy, data_if.rd_rdy}), 256'(0));
      cyc();
      mem_if.ret_valid = 1'b0;
      mem_if.ret_last  = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      inst_if.rd_req = 1'b1;
      inst_if.rd_type = 3'd4;
      inst_if.rd_addr = 32'h1c00_0000;
      inst_if.wr_req = 1'b0;
      inst_if.wr_type = 3'd0;
      inst_if.wr_addr = 32'd0;
      inst_if.wr_wstrb = 4'd0;
      inst_if.wr_data = '0;
      inst_if.wr_rdy = 1'b0;
      data_if.rd_req = 1'b1;
      data_if.rd_type = 3'd2;
      data_if.rd_addr = 32'h0000_00d0;
      data_if.wr_req = 1'b1;
      data_if.wr_type = 3'd4;
      data_if.wr_addr = 32'h0000_0100;
      data_if.wr_wstrb = 4'hf;
      data_if.wr_data = {8{32'h5a5a_0001}};
      mem_if.rd_rdy = 1'b1;
      mem_if.ret_valid = 1'b1;
      mem_if.ret_last = 1'b1;
      mem_if.ret_data = 32'hdead_beef;
      mem_if.wr_rdy = 1'b1;

      // reset state with every input active
      cyc();
      cyc();
      chk("rst_inst_rdy", 256'(inst_if.rd_rdy), 256'(0));
      chk("rst_data_rdy", 256'(data_if.rd_rdy), 256'(0));
      chk("rst_mem_req", 256'(mem_if.rd_req), 256'(0));
      chk("rst_mem_addr", 256'(mem_if.rd_addr), 256'(0));
      chk("rst_ret_i", 256'({inst_if.ret_valid, inst_if.ret_last}), 256'(0));
      chk("rst_ret_d", 256'({data_if.ret_valid, data_if.ret_last}), 256'(0));
      chk("rst_wr_req", 256'(mem_if.wr_req), 256'(0));
      chk("rst_wr_rdy", 256'(data_if.wr_rdy), 256'(0));
      chk("rst_wr_data", mem_if.wr_data, 256'(0));
      inst_if.rd_req = 1'b0;
      data_if.rd_req = 1'b0;
      data_if.wr_req = 1'b0;
      mem_if.ret_valid = 1'b0;
      mem_if.ret_last = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();

      // single inst refill, 8 beats
      inst_if.rd_req = 1'b1;
      inst_if.rd_addr = 32'h1c00_0000;
      mem_if.rd_rdy = 1'b1;
      #1;
      chk("t1_mem_req", 256'(mem_if.rd_req), 256'(1));
      chk("t1_mem_addr", 256'(mem_if.rd_addr), 256'(32'h1c00_0000));
      chk("t1_mem_type", 256'(mem_if.rd_type), 256'(3'd4));
      chk("t1_inst_rdy", 256'(inst_if.rd_rdy), 256'(1));
      chk("t1_data_rdy", 256'(data_if.rd_rdy), 256'(0));
      cyc();
      inst_if.rd_req = 1'b0;
      for (int i = 0; i < 8; i++)
         beat(1'b1, 32'h1000_0000 + 32'(i), i == 7);

      // both masters requesting: starve rotation
      inst_if.rd_req = 1'b1;
      inst_if.rd_addr = 32'h0000_0010;
      data_if.rd_req = 1'b1;
      data_if.rd_addr = 32'h0000_00d0;
      for (int g = 0; g < 10; g++) begin
         #1;
         chk("t2_mem_req", 256'(mem_if.rd_req), 256'(1));
         chk("t2_grant_i", 256'(inst_if.rd_rdy), 256'(order[g] == "I"));
         chk("t2_grant_d", 256'(data_if.rd_rdy), 256'(order[g] == "D"));
         chk("t2_mem_addr", 256'(mem_if.rd_addr),
             256'(order[g] == "I" ? 32'h10 : 32'hd0));
         cyc();
         beat(order[g] == "I", 32'h2000_0000 + 32'(g), 1'b0);
         beat(order[g] == "I", 32'h2100_0000 + 32'(g), 1'b1);
      end

      // data held while bridge stalls, inst keeps asking
      inst_if.rd_addr = 32'h0000_0020;
      data_if.rd_addr = 32'h0000_00a0;
      mem_if.rd_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_hold_addr", 256'(mem_if.rd_addr), 256'(32'ha0));
         chk("t3_hold_irdy", 256'(inst_if.rd_rdy), 256'(0));
         cyc();
      end
      mem_if.rd_rdy = 1'b1;
      #1;
      chk("t3_d_accept", 256'(data_if.rd_rdy), 256'(1));
      chk("t3_i_blocked", 256'(inst_if.rd_rdy), 256'(0));
      cyc();
      data_if.rd_req = 1'b0;

      // write passes through during a data return
      data_if.wr_req = 1'b1;
      data_if.wr_type = 3'd4;
      data_if.wr_addr = 32'h1c00_00f0;
      data_if.wr_wstrb = 4'hf;
      data_if.wr_data = {8{32'hcafe_0042}};
      mem_if.wr_rdy = 1'b1;
      #1;
      chk("t4_wr_req", 256'(mem_if.wr_req), 256'(1));
      chk("t4_wr_rdy", 256'(data_if.wr_rdy), 256'(1));
      chk("t4_wr_addr", 256'(mem_if.wr_addr), 256'(32'h1c00_00f0));
      chk("t4_wr_strb", 256'(mem_if.wr_wstrb), 256'(4'hf));
      chk("t4_wr_data", mem_if.wr_data, {8{32'hcafe_0042}});
      beat(1'b0, 32'h3000_0000, 1'b0);
      beat(1'b0, 32'h3000_0001, 1'b0);
      data_if.wr_req = 1'b0;
      mem_if.wr_rdy = 1'b0;
      beat(1'b0, 32'h3000_0002, 1'b0);
      beat(1'b0, 32'h3000_0003, 1'b1);

      // inst held while data joins in
      mem_if.rd_rdy = 1'b0;
      #1;
      chk("t3b_addr0", 256'(mem_if.rd_addr), 256'(32'h20));
      cyc();
      data_if.rd_req = 1'b1;
      data_if.rd_addr = 32'h0000_00b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("t3b_hold_addr", 256'(mem_if.rd_addr), 256'(32'h20));
         cyc();
      end
      mem_if.rd_rdy = 1'b1;
      #1;
      chk("t3b_i_accept", 256'(inst_if.rd_rdy), 256'(1));
      chk("t3b_d_blocked", 256'(data_if.rd_rdy), 256'(0));
      chk("t3b_addr", 256'(mem_if.rd_addr), 256'(32'h20));
      cyc();
      inst_if.rd_req = 1'b0;
      data_if.rd_req = 1'b0;
      beat(1'b1, 32'h4000_0000, 1'b1);

      // reset in the middle of an inst refill
      inst_if.rd_req = 1'b1;
      inst_if.rd_addr = 32'h1c00_0100;
      #1;
      chk("t5_i_accept", 256'(inst_if.rd_rdy), 256'(1));
      cyc();
      inst_if.rd_req = 1'b0;
      for (int i = 0; i < 4; i++)
         beat(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
      reset = 1'b1;
      data_if.rd_req = 1'b1;
      data_if.rd_addr = 32'h0000_00c0;
      data_if.wr_req = 1'b1;
      mem_if.wr_rdy = 1'b1;
      for (int i = 4; i < 8; i++) begin
         mem_if.ret_valid = 1'b1;
         mem_if.ret_last = (i == 7);
         mem_if.ret_data = 32'h5000_0000 + 32'(i);
         #1;
         chk("t5_drop_valid", 256'(inst_if.ret_valid), 256'(0));
         chk("t5_drop_last", 256'(inst_if.ret_last), 256'(0));
         chk("t5_rst_rd", 256'({mem_if.rd_req, data_if.rd_rdy}), 256'(0));
         chk("t5_rst_wr", 256'({mem_if.wr_req, data_if.wr_rdy}), 256'(0));
         cyc();
      end
      mem_if.ret_valid = 1'b0;
      mem_if.ret_last = 1'b0;
      data_if.wr_req = 1'b0;
      mem_if.wr_rdy = 1'b0;
      reset = 1'b0;
      #1;
      chk("t5_post_d", 256'(data_if.rd_rdy), 256'(1));
      chk("t5_post_addr", 256'(mem_if.rd_addr), 256'(32'hc0));
      cyc();
      data_if.rd_req = 1'b0;
      beat(1'b0, 32'h5100_0000, 1'b1);

      // reset clears a saturated starve counter
      inst_if.rd_req = 1'b1;
      data_if.rd_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t6_d_grant", 256'(data_if.rd_rdy), 256'(1));
         cyc();
         beat(1'b0, 32'h6000_0000 + 32'(k), 1'b1);
      end
      reset = 1'b1;
      #1;
      chk("t6_rst_rdy", 256'({inst_if.rd_rdy, data_if.rd_rdy}), 256'(0));
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("t6_post_d", 256'(data_if.rd_rdy), 256'(1));
      chk("t6_post_i", 256'(inst_if.rd_rdy), 256'(0));
      cyc();
      inst_if.rd_req = 1'b0;
      data_if.rd_req = 1'b0;
      beat(1'b0, 32'h6100_0000, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
